// File: rtl/seg_display_scan_if.sv
// Bundle of the display driver's data/control signals.
// The master side (counter/calculator logic) drives cnt_in, val_in, load
// and blank_en. The slave side (the display driver) returns the panel
// outputs, the load acknowledge, and a read-only view of its slot sequencer.
//
// Handshake: load is a single-cycle request and has no ready signal; the
// driver always accepts it. ld_ack is a one-cycle pulse that marks the first
// cycle in which the loaded value is on the display. Any number of loads may
// happen before that cycle, and only the newest one is shown and acked.
interface seg_display_scan_if;
  logic [3:0]  cnt_in;
  logic [11:0] val_in;
  logic        load;
  logic        blank_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        ld_ack;
  logic        dbg_slot;   // 0 = BLANK cycle, 1 = ON cycle
  logic [1:0]  dbg_dig;    // digit index of the current slot

  modport master (
    output cnt_in, val_in, load, blank_en,
    input  an, seg, ld_ack, dbg_slot, dbg_dig
  );

  modport slave (
    input  cnt_in, val_in, load, blank_en,
    output an, seg, ld_ack, dbg_slot, dbg_dig
  );
endinterface

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment driver.
// Digit 0 shows the live counter nibble, which is re-captured once per
// frame. Digits 3..1 show a 12-bit value that changes only at a frame start,
// so a partially updated number is never on the panel. Every slot opens with
// a one-cycle blank to avoid ghosting between digits.
//
// The state registers describe the cycle currently shown on the outputs.
// Each clock edge computes the next slot and the panel image for that slot,
// and registers both together. No input reaches an output without passing
// through a register.
module seg_display_scan #(
  parameter int REFRESH_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_display_scan_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } slot_e;

  // Slot sequencer state
  slot_e       state_q, state_n;
  logic [PW-1:0] pre_q, pre_n;
  logic [1:0]  dig_q, dig_n;

  // Data path state
  logic [11:0] disp_q, disp_n;
  logic [11:0] pend_q, pend_n;
  logic        pend_v_q, pend_v_n;
  logic [3:0]  cnt_q, cnt_n;

  // Registered outputs
  logic [3:0]  an_q, an_n;
  logic [6:0]  seg_q, seg_n;
  logic        ack_q, ack_n;

  // Helper signals
  logic        pre_wrap;
  logic        frame_start;
  logic        cnt_cap;
  logic [3:0]  nib;
  logic        dark;

  // Active-low hex glyphs, {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next slot: the prescaler counts the dwell, and the digit steps down
  // (3,2,1,0,3) each time the prescaler wraps
  always_comb begin
    pre_wrap    = (pre_q == PRE_LAST);
    pre_n       = pre_wrap ? '0 : pre_q + PW'(1);
    dig_n       = pre_wrap ? dig_q - 2'd1 : dig_q;
    state_n     = (pre_n == '0) ? S_BLANK : S_ON;
    frame_start = pre_wrap && (dig_q == 2'd0);
  end

  // Next data state: pending load capture, frame-synchronous apply,
  // and the counter snapshot taken during the digit-0 blank cycle
  always_comb begin
    disp_n   = disp_q;
    pend_n   = pend_q;
    pend_v_n = pend_v_q;
    ack_n    = 1'b0;
    cnt_cap  = (state_q == S_BLANK) && (dig_q == 2'd0);
    cnt_n    = cnt_cap ? bus.cnt_in : cnt_q;

    if (bus.load) begin
      pend_n   = bus.val_in;
      pend_v_n = 1'b1;
    end

    if (frame_start) begin
      if (bus.load) begin
        // A load arriving on the frame boundary goes straight to the display
        disp_n   = bus.val_in;
        pend_v_n = 1'b0;
        ack_n    = 1'b1;
      end else if (pend_v_q) begin
        disp_n   = pend_q;
        pend_v_n = 1'b0;
        ack_n    = 1'b1;
      end
    end
  end

  // Panel image for the next cycle, built from the next slot and next data
  always_comb begin
    an_n = 4'b1111;
    seg_n = 7'b1111111;
    nib  = 4'h0;
    dark = 1'b0;

    case (dig_n)
      2'd3: begin
        nib  = disp_n[11:8];
        dark = (disp_n[11:8] == 4'h0);
      end
      2'd2: begin
        nib  = disp_n[7:4];
        dark = (disp_n[11:4] == 8'h00);
      end
      2'd1: begin
        nib  = disp_n[3:0];
        dark = (disp_n == 12'h000);
      end
      default: begin
        nib  = cnt_n;
        dark = 1'b0;
      end
    endcase

    if (state_n == S_ON) begin
      an_n  = ~(4'b0001 << dig_n);
      seg_n = (bus.blank_en && dark) ? 7'b1111111 : hex7(nib);
    end
  end

  // Sequencer registers; reset parks on the digit-3 blank cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      pre_q   <= '0;
      dig_q   <= 2'd3;
    end else begin
      state_q <= state_n;
      pre_q   <= pre_n;
      dig_q   <= dig_n;
    end
  end

  // Data and output registers; reset drops any pending load with no ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q   <= 12'h000;
      pend_q   <= 12'h000;
      pend_v_q <= 1'b0;
      cnt_q    <= 4'h0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      ack_q    <= 1'b0;
    end else begin
      disp_q   <= disp_n;
      pend_q   <= pend_n;
      pend_v_q <= pend_v_n;
      cnt_q    <= cnt_n;
      an_q     <= an_n;
      seg_q    <= seg_n;
      ack_q    <= ack_n;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.ld_ack   = ack_q;
  assign bus.dbg_slot = state_q;
  assign bus.dbg_dig  = dig_q;

endmodule
